instruction_fetch_unit: RTL

Pipeline fetch stage that drives the word-aligned byte address into the instruction memory and collects the returned instruction words. The instruction memory returns data one cycle after the address is presented. The unit owns the fetch PC and issues sequential fetches (PC+4). It absorbs decode-stage stalls in a 2-entry buffer so no in-flight word is lost, and flushes on branch/jump redirect. It sits between the instruction memory and the IF/ID boundary.

---
 rtl/instruction_fetch_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues sequential word fetches to a 1-cycle-latency
// instruction memory and buffers returned words in a 2-entry FIFO toward decode.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic        misalign
);

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        inflight_v_q, inflight_v_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   logic [31:0] fifo_instr_q [2];
   logic [31:0] fifo_instr_d [2];
   logic [31:0] fifo_pc_q [2];
   logic [31:0] fifo_pc_d [2];
   logic [1:0]  count_q, count_d;
   logic        misalign_q, misalign_d;

   logic        pop, push, issue, wr_hi;
   logic [2:0]  occ;

   always_comb begin
      pop   = (count_q != 2'd0) && !stall && !redirect;
      push  = inflight_v_q && !redirect;
      // Occupancy the FIFO could reach once the in-flight word lands; issue only if it leaves room.
      occ   = {1'b0, count_q} + {2'b00, inflight_v_q} - {2'b00, pop};
      issue = !redirect && (occ < 3'd2);
      wr_hi = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

      fetch_pc_d    = fetch_pc_q;
      inflight_v_d  = inflight_v_q;
      inflight_pc_d = inflight_pc_q;
      fifo_instr_d  = fifo_instr_q;
      fifo_pc_d     = fifo_pc_q;
      count_d       = count_q;
      misalign_d    = 1'b0;

      if (redirect) begin
         count_d      = 2'd0;
         inflight_v_d = 1'b0;
         fetch_pc_d   = {redirect_pc[31:2], 2'b00};
         misalign_d   = |redirect_pc[1:0];
      end else begin
         inflight_v_d = issue;
         if (issue) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
         end
         if (pop) begin
            fifo_instr_d[0] = fifo_instr_q[1];
            fifo_pc_d[0]    = fifo_pc_q[1];
         end
         // Push lands behind whatever remains after this cycle's pop.
         if (push) begin
            if (wr_hi) begin
               fifo_instr_d[1] = imem_instr;
               fifo_pc_d[1]    = inflight_pc_q;
            end else begin
               fifo_instr_d[0] = imem_instr;
               fifo_pc_d[0]    = inflight_pc_q;
            end
         end
         count_d = count_q - {1'b0, pop} + {1'b0, push};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         inflight_v_q  <= 1'b0;
         inflight_pc_q <= '0;
         fifo_instr_q  <= '{default: '0};
         fifo_pc_q     <= '{default: '0};
         count_q       <= 2'd0;
         misalign_q    <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_v_q  <= inflight_v_d;
         inflight_pc_q <= inflight_pc_d;
         fifo_instr_q  <= fifo_instr_d;
         fifo_pc_q     <= fifo_pc_d;
         count_q       <= count_d;
         misalign_q    <= misalign_d;
      end
   end

   assign imem_pc     = fetch_pc_q;
   assign if_valid    = (count_q != 2'd0);
   assign if_instr    = fifo_instr_q[0];
   assign if_pc       = fifo_pc_q[0];
   assign if_pc_plus4 = if_valid ? (fifo_pc_q[0] + 32'd4) : 32'd0;
   assign misalign    = misalign_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (count_q == 2'd2) && !pop));

endmodule
